// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

   localparam int unsigned ADDRESS_SIZE_DFLT = 2;
   localparam int unsigned PTR_W             = ADDRESS_SIZE_DFLT + 1;
   localparam logic [31:0] PTR_RST           = '0;

   // Wrap-aware increment: the address field runs 0..depth-1, then clears and flips the wrap bit at bit [aw].
   function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                            input int unsigned depth,
                                            input int unsigned aw);
      logic [31:0] amask;
      logic [31:0] addr;
      logic [31:0] wrap;
      amask = (32'd1 << aw) - 32'd1;
      addr  = ptr & amask;
      wrap  = (ptr >> aw) & 32'd1;
      if (addr == depth - 32'd1) return (wrap ^ 32'd1) << aw;
      else                       return (wrap << aw) | (addr + 32'd1);
   endfunction

endpackage

// File: rtl/fifo_ptr_inc.sv
// Single wrap-aware FIFO pointer register; exposes both current and next value so flags can be precomputed.
module fifo_ptr_inc
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = ADDRESS_SIZE_DFLT,
   parameter int unsigned PW    = PTR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [PW-1:0] ptr,
   output logic [PW-1:0] ptr_nxt
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) ptr_d = PW'(ptr_next(32'(ptr_q), DEPTH, AW));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= PW'(PTR_RST);
      else        ptr_q <= ptr_d;
   end

   assign ptr     = ptr_q;
   assign ptr_nxt = ptr_d;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer pair with registered full/empty/almost flags and fill count.
// Optional sticky overflow/underflow outputs are enabled with FIFO_PTR_ERR_FLAGS_EN.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned MEMORY_DEPTH = 4,
   parameter int unsigned ADDRESS_SIZE = 2,
   parameter int unsigned AF_LEVEL     = 3,
   parameter int unsigned AE_LEVEL     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_req,
   input  logic                    rd_req,
   output logic                    wr_en,
   output logic                    rd_en,
   output logic [ADDRESS_SIZE-1:0] w_addr,
   output logic [ADDRESS_SIZE-1:0] r_addr,
   output logic [ADDRESS_SIZE:0]   w_ptr,
   output logic [ADDRESS_SIZE:0]   r_ptr,
   output logic [ADDRESS_SIZE:0]   count,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty
`ifdef FIFO_PTR_ERR_FLAGS_EN
   ,
   output logic                    overflow,
   output logic                    underflow
`endif
);

   localparam int unsigned AW = ADDRESS_SIZE;
   localparam int unsigned PW = ADDRESS_SIZE + 1;

   logic [PW-1:0] w_nxt, r_nxt;
   logic [PW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;

   assign wr_en = wr_req & ~full_q;
   assign rd_en = rd_req & ~empty_q;

   fifo_ptr_inc #(.DEPTH(MEMORY_DEPTH), .AW(AW), .PW(PW)) u_wptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (wr_en),
      .ptr     (w_ptr),
      .ptr_nxt (w_nxt)
   );

   fifo_ptr_inc #(.DEPTH(MEMORY_DEPTH), .AW(AW), .PW(PW)) u_rptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rd_en),
      .ptr     (r_ptr),
      .ptr_nxt (r_nxt)
   );

   // Flags come from next-state pointers so they are valid in the same cycle the pointers settle.
   always_comb begin
      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (w_nxt == r_nxt);
      full_d  = (w_nxt[AW-1:0] == r_nxt[AW-1:0]) && (w_nxt[AW] != r_nxt[AW]);
      af_d    = (32'(count_d) >= AF_LEVEL);
      ae_d    = (32'(count_d) <= AE_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= (AF_LEVEL == 0);
         ae_q    <= 1'b1;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
      end
   end

   assign w_addr       = w_ptr[AW-1:0];
   assign r_addr       = r_ptr[AW-1:0];
   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

`ifdef FIFO_PTR_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (wr_req & full_q);
      unf_d = unf_q | (rd_req & empty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed scoreboard bench: a depth-4 and a depth-5 controller checked against an independent count-based model.
module tb_fifo_ptr_ctrl;

   typedef struct {
      int cnt; int wp; int rp;
      bit full; bit empty; bit af; bit ae; bit ovf; bit unf;
   } exp_t;

   exp_t sbq[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr0 = 1'b0, rd0 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;

   logic       wen0, ren0, full0, empty0, af0, ae0;
   logic [1:0] wa0, ra0;
   logic [2:0] wp0, rp0, cnt0;
   logic       wen5, ren5, full5, empty5, af5, ae5;
   logic [2:0] wa5, ra5;
   logic [3:0] wp5, rp5, cnt5;
`ifdef FIFO_PTR_ERR_FLAGS_EN
   logic ovf0, unf0, ovf5, unf5;
`endif

   int m_w[2], m_r[2], m_cnt[2];
   bit m_ovf[2], m_unf[2];

   always #5 clk = ~clk;

   fifo_ptr_ctrl #(.MEMORY_DEPTH(4), .ADDRESS_SIZE(2), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .wr_req(wr0), .rd_req(rd0), .wr_en(wen0), .rd_en(ren0),
      .w_addr(wa0), .r_addr(ra0), .w_ptr(wp0), .r_ptr(rp0), .count(cnt0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0)
`ifdef FIFO_PTR_ERR_FLAGS_EN
      , .overflow(ovf0), .underflow(unf0)
`endif
   );

   fifo_ptr_ctrl #(.MEMORY_DEPTH(5), .ADDRESS_SIZE(3), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .wr_req(wr5), .rd_req(rd5), .wr_en(wen5), .rd_en(ren5),
      .w_addr(wa5), .r_addr(ra5), .w_ptr(wp5), .r_ptr(rp5), .count(cnt5),
      .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5)
`ifdef FIFO_PTR_ERR_FLAGS_EN
      , .overflow(ovf5), .underflow(unf5)
`endif
   );

   function automatic int dep(input int s);
      return (s == 0) ? 4 : 5;
   endfunction

   function automatic int aw(input int s);
      return (s == 0) ? 2 : 3;
   endfunction

   // Address field counts 0..depth-1; bit [aw] flips each lap.
   function automatic int adv(input int p, input int s);
      int a, wr;
      a  = p % (1 << aw(s));
      wr = p / (1 << aw(s));
      if (a == dep(s) - 1) return (1 - wr) * (1 << aw(s));
      return p + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_state(input int s);
      exp_t e;
      e.cnt = m_cnt[s]; e.wp = m_w[s]; e.rp = m_r[s];
      e.full = (m_cnt[s] == dep(s)); e.empty = (m_cnt[s] == 0);
      e.af = (m_cnt[s] >= 3); e.ae = (m_cnt[s] <= 1);
      e.ovf = m_ovf[s]; e.unf = m_unf[s];
      return e;
   endfunction

   task automatic check_pop(input int s);
      exp_t  e;
      string p;
      int    mask;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e    = sbq.pop_front();
      p    = (s == 0) ? "d4_" : "d5_";
      mask = (1 << aw(s)) - 1;
      chk({p, "count"}, (s == 0) ? 32'(cnt0) : 32'(cnt5), 32'(e.cnt));
      chk({p, "w_ptr"}, (s == 0) ? 32'(wp0) : 32'(wp5), 32'(e.wp));
      chk({p, "r_ptr"}, (s == 0) ? 32'(rp0) : 32'(rp5), 32'(e.rp));
      chk({p, "w_addr"}, (s == 0) ? 32'(wa0) : 32'(wa5), 32'(e.wp & mask));
      chk({p, "r_addr"}, (s == 0) ? 32'(ra0) : 32'(ra5), 32'(e.rp & mask));
      chk({p, "full"}, (s == 0) ? 32'(full0) : 32'(full5), 32'(e.full));
      chk({p, "empty"}, (s == 0) ? 32'(empty0) : 32'(empty5), 32'(e.empty));
      chk({p, "almost_full"}, (s == 0) ? 32'(af0) : 32'(af5), 32'(e.af));
      chk({p, "almost_empty"}, (s == 0) ? 32'(ae0) : 32'(ae5), 32'(e.ae));
`ifdef FIFO_PTR_ERR_FLAGS_EN
      chk({p, "overflow"}, (s == 0) ? 32'(ovf0) : 32'(ovf5), 32'(e.ovf));
      chk({p, "underflow"}, (s == 0) ? 32'(unf0) : 32'(unf5), 32'(e.unf));
`endif
   endtask

   // Reset is applied with every request high to show it wins.
   task automatic do_reset();
      rst_n = 1'b0;
      wr0 = 1'b1; rd0 = 1'b1; wr5 = 1'b1; rd5 = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr0 = 1'b0; rd0 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_w[s] = 0; m_r[s] = 0; m_cnt[s] = 0; m_ovf[s] = 0; m_unf[s] = 0;
         sbq.push_back(model_state(s));
         check_pop(s);
      end
   endtask

   task automatic step(input int s, input bit wr, input bit rd);
      bit    wen, ren;
      string p;
      p   = (s == 0) ? "d4_" : "d5_";
      wr0 = (s == 0) && wr; rd0 = (s == 0) && rd;
      wr5 = (s == 1) && wr; rd5 = (s == 1) && rd;
      #1;
      wen = wr && (m_cnt[s] != dep(s));
      ren = rd && (m_cnt[s] != 0);
      chk({p, "wr_en"}, (s == 0) ? 32'(wen0) : 32'(wen5), 32'(wen));
      chk({p, "rd_en"}, (s == 0) ? 32'(ren0) : 32'(ren5), 32'(ren));
      if (wr && m_cnt[s] == dep(s)) m_ovf[s] = 1;
      if (rd && m_cnt[s] == 0)      m_unf[s] = 1;
      if (wen) m_w[s] = adv(m_w[s], s);
      if (ren) m_r[s] = adv(m_r[s], s);
      m_cnt[s] = m_cnt[s] + int'(wen) - int'(ren);
      sbq.push_back(model_state(s));
      @(posedge clk); #1;
      wr0 = 1'b0; rd0 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
      check_pop(s);
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();

      // depth 5: w_ptr 1,2,3,4,8 then a rejected sixth write
      repeat (6) step(1, 1'b1, 1'b0);
      chk("d5_w_ptr_wrapped", 32'(wp5), 32'd8);
      repeat (6) step(1, 1'b0, 1'b1);
      chk("d5_r_ptr_wrapped", 32'(rp5), 32'd8);

      // depth 4: count 2 held under 10 simultaneous accesses
      repeat (2) step(0, 1'b1, 1'b0);
      repeat (10) step(0, 1'b1, 1'b1);
      repeat (2) step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1);
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      repeat (4) step(0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b1);
      repeat (2) step(0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);

      do_reset();
      step(0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Parametrised pointer and flag controller for the synchronous single-clock FIFO. It generalises the extra-bit read-address counter to a matched read/write pointer pair. It supports non-power-of-two depth and derives full, empty, almost-full, almost-empty and fill level. It sits between the producer/consumer request interfaces and the dual-port storage array, driving its addresses and enables.

Parameters:
MEMORY_DEPTH, 4, number of storage entries; any value >= 2, power of two not required.
ADDRESS_SIZE, 2, storage address width; 2**ADDRESS_SIZE >= MEMORY_DEPTH is required.
AF_LEVEL, 3, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
wr_req  input  1  producer write request.
rd_req  input  1  consumer read request.
wr_en  output  1  storage write strobe = wr_req & !full (combinational).
rd_en  output  1  storage read strobe = rd_req & !empty (combinational).
w_addr  output  ADDRESS_SIZE  storage write address = w_ptr[ADDRESS_SIZE-1:0].
r_addr  output  ADDRESS_SIZE  storage read address = r_ptr[ADDRESS_SIZE-1:0].
w_ptr  output  ADDRESS_SIZE+1  write pointer; MSB is wrap bit.
r_ptr  output  ADDRESS_SIZE+1  read pointer; MSB is wrap bit.
count  output  ADDRESS_SIZE+1  entries held, 0..MEMORY_DEPTH, registered.
full, empty, almost_full, almost_empty  output  1 each  status flags, registered.

Behaviour:
- Reset (rst_n low at a clock edge): w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). Error flags are also cleared when the optional feature is enabled.
- Pointer advance: on wr_en, w_ptr steps; on rd_en, r_ptr steps.
  - If address field == MEMORY_DEPTH-1: address field becomes 0 and wrap bit toggles.
  - Otherwise: address field +1 and wrap bit unchanged.
  - The address field never reaches MEMORY_DEPTH..2**ADDRESS_SIZE-1.
- Flags are computed from next-state pointers and registered, so they reflect the access one cycle later.
  - empty: next w_ptr == next r_ptr.
  - full: address fields equal and wrap bits differ.
- count next:
  - +1 on wr_en only.
  - -1 on rd_en only.
  - Unchanged on both or neither.
  - count == MEMORY_DEPTH iff full; count == 0 iff empty.
- Simultaneous wr_req & rd_req:
  - Neither full nor empty: both accepted, count unchanged, both pointers step.
  - Full: write rejected, read accepted, count -1 (no bypass).
  - Empty: read rejected, write accepted, count +1.
- Write when full, or read when empty: request ignored, pointers unchanged.
- Reset mid-operation overrides any request in the same cycle.
- Latency: storage strobes are same cycle as the request; flags and count update at the next edge.

Optional Feature:
Macro FIFO_PTR_ERR_FLAGS_EN.
- When defined, adds two output ports, overflow and underflow, each 1 bit.
  - overflow is sticky: set at the edge after wr_req & full.
  - underflow is sticky: set at the edge after rd_req & empty.
  - Both are cleared only by reset.
- When undefined, the ports and logic are absent; rejected requests are silently dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_next(ptr, depth) for wrap-aware increment;
  - localparam PTR_W = ADDRESS_SIZE+1;
  - a reset-value constant for pointers.
- One sub-module is natural: fifo_ptr_inc, a single wrap-aware pointer register with enable. It is instantiated twice, for read and for write.
- Flag and count logic stays in the top module.

Test Plan:
- Reset with wr_req=rd_req=1 held: after release, count=0, empty=1, full=0, w_ptr=r_ptr=0.
- MEMORY_DEPTH=5, ADDRESS_SIZE=3: 5 writes give w_ptr 0→1→2→3→4→8 (addr 0, wrap 1), full=1, count=5. A 6th write is ignored and w_ptr stays 8.
- Full, then 5 reads: r_ptr reaches 8, empty=1, count=0. The 6th read is ignored, rd_en=0.
- Count 2 of 4, wr_req=rd_req=1 for 10 cycles: count stays 2, both pointers advance 10 modulo-wrap steps, and the flags stay constant.
- Full with simultaneous wr_req and rd_req: wr_en=0, rd_en=1, count 4→3, full deasserts next cycle. Empty with both requests: rd_en=0, wr_en=1, count 0→1.
- Defaults AF=3, AE=1: writes from 0 show almost_empty 1,1,0 at count 0,1,2 and almost_full at count 3. With FIFO_PTR_ERR_FLAGS_EN, a write at full sets overflow, which stays 1 until rst_n=0.
